ooo_responder: RTL and testbench

//   Writer side of the reorder queue protocol. Accepts tagged requests in order, holds each for a

---
 rtl/ooo_responder_pkg.sv | 32 +++
 rtl/ooo_responder_if.sv | 44 ++++
 rtl/ooo_responder_lfsr16.sv | 30 +++
 rtl/ooo_responder.sv | 180 ++++++++++++++++++
 tb/tb_ooo_responder.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ooo_responder_pkg.sv
//==============================================================================
// Module : ooo_responder_pkg
// Brief  : Shared definitions for the out-of-order responder. Holds the default
//          tag/payload widths used by the reorder queue, the Galois LFSR
//          polynomial, the LFSR step function and the delay-counter sizing
//          helper.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package ooo_responder_pkg;

    // Defaults shared with the reorder queue index_tag / payload widths.
    localparam int DEF_TAG_W  = 6;
    localparam int DEF_DATA_W = 8;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form.
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // One Galois step: shift right, fold the polynomial in when bit 0 falls out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
    endfunction

    // Bits needed to hold a delay counter value 0..max_delay.
    function automatic int dly_width(input int max_delay);
        return (max_delay < 1) ? 1 : $clog2(max_delay + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ooo_responder_if.sv
//==============================================================================
// Module : ooo_responder_if
// Brief  : Request / response bundle of the out-of-order responder.
//          slave  modport : responder side (accepts requests, drives responses)
//          master modport : requester / downstream side
//          Signals: req_valid, req_ready, req_tag, req_d, rsp_stall, rsp_wr_en,
//                   rsp_tag, rsp_d, outstanding, err
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface ooo_responder_if
    import ooo_responder_pkg::*;
#(
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SLOTS  = 8
);
    localparam int CNT_W = $clog2(SLOTS) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [TAG_W-1:0]  req_tag;
    logic [DATA_W-1:0] req_d;
    logic              rsp_stall;
    logic              rsp_wr_en;
    logic [TAG_W-1:0]  rsp_tag;
    logic [DATA_W-1:0] rsp_d;
    logic [CNT_W-1:0]  outstanding;
    logic              err;

    modport slave (
        input  req_valid, req_tag, req_d, rsp_stall,
        output req_ready, rsp_wr_en, rsp_tag, rsp_d, outstanding, err
    );

    modport master (
        output req_valid, req_tag, req_d, rsp_stall,
        input  req_ready, rsp_wr_en, rsp_tag, rsp_d, outstanding, err
    );

endinterface

`default_nettype wire

// File: rtl/ooo_responder_lfsr16.sv
//==============================================================================
// Module : lfsr16
// Brief  : Seeded 16-bit Galois LFSR, advances one step every clock out of
//          reset.
//          Ports: clk, rst (async, active-high), state[15:0] (current value)
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module lfsr16
    import ooo_responder_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= lfsr_next(state);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ooo_responder.sv
//==============================================================================
// Module : ooo_responder
// Brief  : Accepts tagged requests in order, holds each in a slot for
//          MIN_DELAY + (lfsr & DELAY_MASK) cycles and returns them out of order
//          as (rsp_wr_en, rsp_tag, rsp_d), one per cycle, round-robin among
//          the slots whose delay has expired.
//          Ports: clk, rst (async, active-high), bus (ooo_responder_if.slave)
//          Build option: OOO_RESP_DUP_CHECK_EN enables the sticky
//          duplicate-tag flag on err; otherwise err is tied low.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module ooo_responder
    import ooo_responder_pkg::*;
#(
    parameter int          TAG_W      = DEF_TAG_W,
    parameter int          DATA_W     = DEF_DATA_W,
    parameter int          SLOTS      = 8,
    parameter int          MIN_DELAY  = 1,
    parameter int          DELAY_MASK = 'hF,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst,
    ooo_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(SLOTS);
    localparam int CNT_W = IDX_W + 1;
    localparam int DLY_W = dly_width(MIN_DELAY + DELAY_MASK);

    logic [SLOTS-1:0]  slot_valid;
    logic [TAG_W-1:0]  slot_tag [SLOTS];
    logic [DATA_W-1:0] slot_d   [SLOTS];
    logic [DLY_W-1:0]  slot_dly [SLOTS];

    logic [IDX_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  count;
    logic              wr_en;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_d;
    logic [15:0]       lfsr_state;

    logic [SLOTS-1:0]  eligible;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand;
    logic              ready;
    logic              accept;
    logic              issue;
    logic [15:0]       rnd;
    logic [DLY_W-1:0]  load_dly;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_state)
    );

    // Ready depends only on the registered occupancy.
    assign ready  = (count != CNT_W'(SLOTS));
    assign accept = bus.req_valid && ready;

    assign rnd      = lfsr_state & 16'(DELAY_MASK);
    assign load_dly = DLY_W'(MIN_DELAY) + DLY_W'(rnd);

    always_comb begin
        eligible    = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < SLOTS; i++) begin
            eligible[i] = slot_valid[i] && (slot_dly[i] == '0);
        end
        // Scan downwards so the lowest free index wins.
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        // Offsets scanned downwards so rr_ptr+1 has top priority and rr_ptr
        // itself (offset SLOTS wraps to 0) comes last. SLOTS is a power of two,
        // so the index arithmetic wraps for free.
        for (int off = SLOTS; off >= 1; off--) begin
            cand = rr_ptr + IDX_W'(off);
            if (eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign issue = !bus.rsp_stall && grant_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_tag[i] <= '0;
                slot_d[i]   <= '0;
                slot_dly[i] <= '0;
            end
            rr_ptr  <= '0;
            count   <= '0;
            wr_en   <= 1'b0;
            out_tag <= '0;
            out_d   <= '0;
        end else begin
            // Counters keep running down even while responses are stalled.
            for (int i = 0; i < SLOTS; i++) begin
                if (slot_valid[i] && (slot_dly[i] != '0)) begin
                    slot_dly[i] <= slot_dly[i] - 1'b1;
                end
            end
            if (issue) begin
                slot_valid[grant_idx] <= 1'b0;
                wr_en                 <= 1'b1;
                out_tag               <= slot_tag[grant_idx];
                out_d                 <= slot_d[grant_idx];
                rr_ptr                <= grant_idx;
            end else begin
                wr_en <= 1'b0;
            end
            // free_idx comes from pre-edge state, so it never collides with
            // the slot being granted on this same edge.
            if (accept && free_found) begin
                slot_valid[free_idx] <= 1'b1;
                slot_tag[free_idx]   <= bus.req_tag;
                slot_d[free_idx]     <= bus.req_d;
                slot_dly[free_idx]   <= load_dly;
            end
            case ({accept, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef OOO_RESP_DUP_CHECK_EN
    logic dup_hit;
    logic err_q;

    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_valid[i] && (slot_tag[i] == bus.req_tag)) begin
                dup_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && dup_hit) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.req_ready   = ready;
    assign bus.rsp_wr_en   = wr_en;
    assign bus.rsp_tag     = out_tag;
    assign bus.rsp_d       = out_d;
    assign bus.outstanding = count;

endmodule

`default_nettype wire

// File: tb/tb_ooo_responder.sv
//==============================================================================
// Module : tb_ooo_responder
// Brief  : Self-checking bench for ooo_responder. dut_a uses default
//          parameters and is tracked every cycle by a due-time reference
//          model; dut_b (MIN_DELAY=2, DELAY_MASK=0) checks exact latency.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_ooo_responder;
    import ooo_responder_pkg::*;

    localparam int          SLOTS     = 8;
    localparam int          MIN_DELAY = 1;
    localparam int          MASK      = 15;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ooo_responder_if #(.TAG_W(6), .DATA_W(8), .SLOTS(SLOTS)) bus_a ();
    ooo_responder_if #(.TAG_W(6), .DATA_W(8), .SLOTS(SLOTS)) bus_b ();

    ooo_responder #(
        .TAG_W(6), .DATA_W(8), .SLOTS(SLOTS), .MIN_DELAY(MIN_DELAY),
        .DELAY_MASK(MASK), .LFSR_SEED(SEED)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

    ooo_responder #(
        .TAG_W(6), .DATA_W(8), .SLOTS(SLOTS), .MIN_DELAY(2),
        .DELAY_MASK(0), .LFSR_SEED(SEED)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

`ifdef OOO_RESP_DUP_CHECK_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: each held request remembers the edge number at which
    // its delay ends; it may be issued on any later edge.
    bit          m_valid [SLOTS];
    logic [5:0]  m_tag   [SLOTS];
    logic [7:0]  m_d     [SLOTS];
    int          m_due   [SLOTS];
    int          m_ptr;
    logic [15:0] m_lfsr;
    int          m_cnt;
    bit          m_wr;
    logic [5:0]  m_rtag;
    logic [7:0]  m_rd;
    bit          m_err;
    bit          m_acc;
    int          edge_no;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_d[i] = '0; m_due[i] = 0;
        end
        m_ptr = 0; m_lfsr = SEED; m_cnt = 0; m_wr = 1'b0;
        m_rtag = '0; m_rd = '0; m_err = 1'b0; m_acc = 1'b0; edge_no = 0;
    endtask

    // Advance one clock: predict from pre-edge inputs/state, then compare.
    task automatic tick();
        int k, free_i, g;
        bit dup;
        k = edge_no + 1;
        free_i = -1;
        for (int i = 0; i < SLOTS; i++)
            if (!m_valid[i] && free_i < 0) free_i = i;
        m_acc = bus_a.req_valid && (m_cnt != SLOTS);
        g = -1;
        if (!bus_a.rsp_stall)
            for (int off = 1; off <= SLOTS; off++) begin
                int idx;
                idx = (m_ptr + off) % SLOTS;
                if (g < 0 && m_valid[idx] && k > m_due[idx]) g = idx;
            end
        dup = 1'b0;
        if (m_acc)
            for (int i = 0; i < SLOTS; i++)
                if (m_valid[i] && m_tag[i] == bus_a.req_tag) dup = 1'b1;
        if (DUP_EN && dup) m_err = 1'b1;
        if (g >= 0) begin
            m_wr = 1'b1; m_rtag = m_tag[g]; m_rd = m_d[g];
            m_valid[g] = 1'b0; m_ptr = g; m_cnt--;
        end else begin
            m_wr = 1'b0;
        end
        if (m_acc) begin
            m_valid[free_i] = 1'b1;
            m_tag[free_i]   = bus_a.req_tag;
            m_d[free_i]     = bus_a.req_d;
            m_due[free_i]   = k + MIN_DELAY + int'(m_lfsr & 16'(MASK));
            m_cnt++;
        end
        if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
        else           m_lfsr = m_lfsr >> 1;
        @(posedge clk);
        edge_no = k;
        #1;
        chk("a_wr_en",       bus_a.rsp_wr_en,   m_wr);
        chk("a_rsp_tag",     bus_a.rsp_tag,     m_rtag);
        chk("a_rsp_d",       bus_a.rsp_d,       m_rd);
        chk("a_outstanding", bus_a.outstanding, m_cnt);
        chk("a_req_ready",   bus_a.req_ready,   (m_cnt != SLOTS));
        chk("a_err",         bus_a.err,         m_err);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus_a.req_valid = 1'b0;
        bus_a.rsp_stall = 1'b0;
        while (m_cnt != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(name, m_cnt, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int tag_nxt, n, acc_edge, first_wr_edge, wr_cnt, max_ret;
        bit ooo;
        int         got_cnt [64];
        logic [7:0] sent_d  [64];
        logic [7:0] got_d   [64];

        bus_a.req_valid = 1'b0; bus_a.req_tag = '0; bus_a.req_d = '0; bus_a.rsp_stall = 1'b0;
        bus_b.req_valid = 1'b0; bus_b.req_tag = '0; bus_b.req_d = '0; bus_b.rsp_stall = 1'b0;
        model_reset();

        // 1: reset state
        #50 rst = 1'b0;
        chk("rst_a_wr_en",  bus_a.rsp_wr_en,   0);
        chk("rst_a_tag",    bus_a.rsp_tag,     0);
        chk("rst_a_d",      bus_a.rsp_d,       0);
        chk("rst_a_out",    bus_a.outstanding, 0);
        chk("rst_a_ready",  bus_a.req_ready,   1);
        chk("rst_a_err",    bus_a.err,         0);
        chk("rst_b_out",    bus_b.outstanding, 0);
        chk("rst_b_ready",  bus_b.req_ready,   1);

        // 2: fixed delay 2 on dut_b -> response visible after E+3
        bus_b.req_valid = 1'b1; bus_b.req_tag = 6'd5; bus_b.req_d = 8'hA5;
        tick();
        bus_b.req_valid = 1'b0;
        chk("lat_b_out_after_E", bus_b.outstanding, 1);
        chk("lat_b_wr_E",        bus_b.rsp_wr_en,   0);
        tick();
        chk("lat_b_wr_E1",       bus_b.rsp_wr_en,   0);
        tick();
        chk("lat_b_wr_E2",       bus_b.rsp_wr_en,   0);
        tick();
        chk("lat_b_wr_E3",       bus_b.rsp_wr_en,   1);
        chk("lat_b_tag_E3",      bus_b.rsp_tag,     5);
        chk("lat_b_d_E3",        bus_b.rsp_d,       8'hA5);
        tick();
        chk("lat_b_wr_E4",       bus_b.rsp_wr_en,   0);
        chk("lat_b_out_E4",      bus_b.outstanding, 0);
        chk("lat_b_tag_hold",    bus_b.rsp_tag,     5);

        // 3: fill all slots while stalled, ninth request must wait
        bus_a.rsp_stall = 1'b1;
        bus_a.req_valid = 1'b1;
        tag_nxt = 10;
        for (int i = 0; i < 8; i++) begin
            bus_a.req_tag = 6'(tag_nxt); bus_a.req_d = 8'($urandom);
            tick();
            if (m_acc) tag_nxt++;
        end
        chk("full_out",   bus_a.outstanding, 8);
        chk("full_ready", bus_a.req_ready,   0);
        bus_a.req_tag = 6'(tag_nxt); bus_a.req_d = 8'($urandom);
        tick();
        chk("full_held_out", bus_a.outstanding, 8);
        bus_a.rsp_stall = 1'b0;
        acc_edge = -1; first_wr_edge = -1; n = 0;
        while (acc_edge < 0 && n < 50) begin
            tick();
            if (bus_a.rsp_wr_en && first_wr_edge < 0) first_wr_edge = edge_no;
            if (m_acc) acc_edge = edge_no;
            n++;
        end
        chk("ninth_after_free", acc_edge, first_wr_edge + 1);
        drain("drain3_timeout");

        // 4: stall with four held, then four back-to-back responses
        bus_a.rsp_stall = 1'b1;
        bus_a.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_a.req_tag = 6'(20 + i); bus_a.req_d = 8'($urandom);
            tick();
        end
        bus_a.req_valid = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_a.rsp_wr_en) wr_cnt++;
        end
        chk("stall_no_wr", wr_cnt, 0);
        chk("stall_out4",  bus_a.outstanding, 4);
        bus_a.rsp_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("release_consecutive_wr", bus_a.rsp_wr_en, 1);
        end
        chk("release_out0", bus_a.outstanding, 0);

        // 5: tags 0..63 at random rate with occasional stall
        for (int t = 0; t < 64; t++) begin got_cnt[t] = 0; sent_d[t] = '0; got_d[t] = '0; end
        tag_nxt = 0; n = 0; max_ret = -1; ooo = 1'b0;
        while ((tag_nxt < 64 || m_cnt != 0) && n < 3000) begin
            bus_a.req_valid = (tag_nxt < 64) && ($urandom_range(0, 1) == 1);
            bus_a.req_tag   = 6'(tag_nxt);
            bus_a.req_d     = 8'($urandom);
            bus_a.rsp_stall = ($urandom_range(0, 7) == 0);
            if (tag_nxt < 64) sent_d[tag_nxt] = bus_a.req_d;
            tick();
            if (m_acc) tag_nxt++;
            if (bus_a.rsp_wr_en) begin
                got_cnt[bus_a.rsp_tag]++;
                got_d[bus_a.rsp_tag] = bus_a.rsp_d;
                if (int'(bus_a.rsp_tag) < max_ret) ooo = 1'b1;
                if (int'(bus_a.rsp_tag) > max_ret) max_ret = int'(bus_a.rsp_tag);
            end
            n++;
        end
        chk("rand_all_sent", tag_nxt, 64);
        for (int t = 0; t < 64; t++) begin
            chk("rand_tag_once",  got_cnt[t], 1);
            chk("rand_data_kept", got_d[t],   sent_d[t]);
        end
        chk("rand_out_of_order", ooo, 1);

        // 6: duplicate tag while outstanding
        bus_a.rsp_stall = 1'b1;
        bus_a.req_valid = 1'b1;
        bus_a.req_tag = 6'd3; bus_a.req_d = 8'h11;
        tick();
        bus_a.req_d = 8'h22;
        tick();
        bus_a.req_valid = 1'b0;
        tick();
        chk("dup_err_set", bus_a.err, DUP_EN);
        chk("dup_out2",    bus_a.outstanding, 2);
        drain("drain6_timeout");
        chk("dup_err_sticky", bus_a.err, DUP_EN);
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model_reset();
        chk("dup_err_cleared", bus_a.err,         0);
        chk("rst2_out",        bus_a.outstanding, 0);
        chk("rst2_wr_en",      bus_a.rsp_wr_en,   0);
        for (int i = 0; i < 4; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
